// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter family.
// Holds the default datapath and shift-amount widths, the width of the
// per-operation stage counter, the state encoding of the controller
// FSM, and the shift-operation type (SLL / SLLW).
package shifter_pkg;

    localparam int XLEN    = 64;
    localparam int SHAMT_W = 6;
    // Counter that walks stages 0..SHAMT_W-1.
    localparam int STAGE_W = 3;
    // In word mode the 32-position stage is suppressed.  A 32-bit shift
    // amount only uses b[4:0].
    localparam int WORD_SKIP_STAGE = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        OP_SLL  = 1'b0,
        OP_SLLW = 1'b1
    } shift_op_t;

endpackage

// File: rtl/left_shift_stage.sv
// One stage of an iterative logical left shifter.
// Applies a shift of 2^stage positions when en is set.  In word mode the
// 32-position stage passes the value through unchanged.
// Ports:
//   value   - operand entering the stage
//   stage   - stage index (0..SHAMT_W-1)
//   en      - shift-amount bit for this stage
//   word    - 1 for SLLW, 0 for SLL
//   shifted - stage result
module left_shift_stage #(
    parameter int XLEN    = shifter_pkg::XLEN,
    parameter int SHAMT_W = shifter_pkg::SHAMT_W,
    parameter int STAGE_W = shifter_pkg::STAGE_W
) (
    input  logic [XLEN-1:0]    value,
    input  logic [STAGE_W-1:0] stage,
    input  logic               en,
    input  logic               word,
    output logic [XLEN-1:0]    shifted
);
    import shifter_pkg::*;

    // Each candidate is a constant shift, so this is just wiring; the
    // only logic is the stage-index select below.
    logic [XLEN-1:0] cand [SHAMT_W];

    generate
        for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_cand
            assign cand[gi] = value << (1 << gi);
        end
    endgenerate

    logic skip;
    assign skip = word && (stage == STAGE_W'(WORD_SKIP_STAGE));

    always_comb begin
        shifted = value;
        if (en && !skip) begin
            for (int k = 0; k < SHAMT_W; k++) begin
                if (stage == STAGE_W'(k)) begin
                    shifted = cand[k];
                end
            end
        end
    end

endmodule

// File: rtl/left_shift_unit.sv
// Iterative logical left shifter implementing SLL and SLLW.
// The operation is accepted on an edge where start=1 and the unit is
// idle.  It then spends one cycle per shift-amount bit. This gives a
// fixed latency regardless of the amount.  After the last stage, the
// result is presented on s and done pulses for one cycle. Then the unit
// becomes idle again.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset, aborts any operation
//   start - request, sampled only while busy=0
//   a     - operand, b - shift amount, word - 1 selects SLLW
//   busy  - operation in progress or result being presented
//   done  - one-cycle pulse, s holds a new result
//   s     - result, held until the next done or reset
module left_shift_unit #(
    parameter int XLEN    = shifter_pkg::XLEN,
    parameter int SHAMT_W = shifter_pkg::SHAMT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [XLEN-1:0]    a,
    input  logic [SHAMT_W-1:0] b,
    input  logic               word,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    s
);
    import shifter_pkg::*;

    state_t               state_reg;
    logic [XLEN-1:0]      work_reg;
    logic [SHAMT_W-1:0]   b_reg;
    shift_op_t            op_reg;
    logic [STAGE_W-1:0]   stage_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [XLEN-1:0]      s_reg;

    logic [XLEN-1:0]      stage_out;
    logic [XLEN-1:0]      final_value;
    logic                 last_stage;

    left_shift_stage #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W),
        .STAGE_W (STAGE_W)
    ) u_stage (
        .value   (work_reg),
        .stage   (stage_reg),
        .en      (b_reg[stage_reg]),
        .word    (op_reg == OP_SLLW),
        .shifted (stage_out)
    );

    assign last_stage = (stage_reg == STAGE_W'(SHAMT_W - 1));

    // In word mode the upper half of work_reg may hold garbage from the
    // full-width stages. Only bits [31:0] are meaningful, so the sign
    // extension replaces the upper half.
    assign final_value = (op_reg == OP_SLLW)
                       ? {{(XLEN-32){stage_out[31]}}, stage_out[31:0]}
                       : stage_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            b_reg     <= '0;
            op_reg    <= OP_SLL;
            stage_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            s_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        work_reg  <= a;
                        b_reg     <= b;
                        op_reg    <= word ? OP_SLLW : OP_SLL;
                        stage_reg <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_reg <= stage_out;
                    if (last_stage) begin
                        stage_reg <= '0;
                        s_reg     <= final_value;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        stage_reg <= stage_reg + STAGE_W'(1);
                    end
                end
                DONE: begin
                    // start is deliberately not sampled here.
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign s    = s_reg;

endmodule

// File: tb/tb_left_shift_unit.sv
// Self-checking bench for left_shift_unit.
// Expected results come from a reference shift model. They are queued
// when an operation is launched, then popped and compared when done
// pulses. Outputs are sampled on the falling edge.
module tb_left_shift_unit;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [63:0] a     = '0;
    logic [5:0]  b     = '0;
    logic        word  = 1'b0;
    logic        busy;
    logic        done;
    logic [63:0] s;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q [$];
    logic [63:0] last_s = '0;

    left_shift_unit #(
        .XLEN    (64),
        .SHAMT_W (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .word  (word),
        .busy  (busy),
        .done  (done),
        .s     (s)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_shift(input logic [63:0] av,
                                              input logic [5:0]  bv,
                                              input logic        wv);
        logic [63:0] t;
        if (wv) begin
            t = av << bv[4:0];
            return {{32{t[31]}}, t[31:0]};
        end
        return av << bv;
    endfunction

    // Runs one operation. It is entered and left on a falling edge.
    task automatic run_op(input logic [63:0] ai, input logic [5:0] bi,
                          input logic wi, input string name);
        int n;
        logic [63:0] e;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_wait: busy=%b required 0", name, busy);
        end
        a = ai; b = bi; word = wi; start = 1'b1;
        exp_q.push_back(ref_shift(ai, bi, wi));
        @(negedge clk);
        n = 1;
        start = 1'b0;
        a = {$urandom, $urandom}; b = 6'($urandom); word = ~wi;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s accept: busy=%b required 1", name, busy);
        end
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != 7) begin
            bad++;
            $display("FAIL %s latency: edges=%0d required 7", name, n);
        end
        e = exp_q.pop_front();
        total++;
        if (done !== 1'b1 || s !== e) begin
            bad++;
            $display("FAIL %s result: s=%h done=%b required s=%h done=1", name, s, done, e);
        end
        last_s = e;
        $display("op %s a=%h b=%0d word=%b s=%h", name, ai, bi, wi, s);
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s pulse_end: done=%b busy=%b required 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || s !== 64'h0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b s=%h required 0 0 0", busy, done, s);
        end
        start = 1'b0;
        reset = 1'b0;
        // The first edge with reset low must accept the request.
        run_op(64'h1234_5678_9abc_def0, 6'd4, 1'b0, "first_after_reset");
    endtask

    task automatic test_directed();
        run_op(64'h1, 6'd63, 1'b0, "sll_b63");
        run_op(64'h0000_0000_4000_0001, 6'd1, 1'b1, "sllw_sext");
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 6'd32, 1'b1, "sllw_b32_ignored");
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 6'd32, 1'b0, "sll_b32");
        run_op(64'hDEAD_BEEF_0123_4567, 6'd0, 1'b0, "sll_b0");
        run_op(64'hDEAD_BEEF_8123_4567, 6'd0, 1'b1, "sllw_b0");
        for (int i = 0; i < 6; i++) begin
            run_op({$urandom, $urandom}, 6'($urandom), 1'($urandom), "random");
        end
    endtask

    task automatic test_walk();
        int bad_before;
        bad_before = bad;
        for (int i = 0; i < 64; i++) begin
            run_op(64'h1, 6'(i), 1'b0, "walk");
        end
        $display("walk errors=%0d", bad - bad_before);
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            a = {$urandom, $urandom}; b = 6'($urandom); word = 1'($urandom);
            @(negedge clk);
            total++;
            if (s !== last_s || done !== 1'b0) begin
                bad++;
                $display("FAIL hold: s=%h done=%b required s=%h done=0", s, done, last_s);
            end
        end
    endtask

    task automatic test_abort();
        int seen;
        a = 64'hFFFF; b = 6'd3; word = 1'b0; start = 1'b1;
        @(negedge clk);            // after E0
        start = 1'b0;
        @(negedge clk);            // after E1
        @(negedge clk);            // after E2
        reset = 1'b1;
        @(negedge clk);            // after E3, which sampled reset
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || s !== 64'h0) begin
            bad++;
            $display("FAIL abort_state: busy=%b done=%b s=%h required 0 0 0", busy, done, s);
        end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL abort_no_done: pulses=%0d required 0", seen);
        end
        run_op(64'h0F0F_0000_0000_00F0, 6'd8, 1'b0, "after_abort");
    endtask

    // start held high throughout. Accepts are expected every 8 cycles,
    // with inputs that differ every cycle.
    task automatic test_back_to_back();
        logic [63:0] ai, e;
        logic [5:0]  bi;
        logic        wi;
        int          c1;
        for (int c = 0; c < 40; c++) begin
            ai = {$urandom, $urandom}; bi = 6'($urandom); wi = 1'($urandom);
            a = ai; b = bi; word = wi; start = 1'b1;
            if (c % 8 == 0) exp_q.push_back(ref_shift(ai, bi, wi));
            @(negedge clk);
            c1 = c + 1;
            total++;
            if (done !== (c1 % 8 == 7) || busy !== (c1 % 8 != 0)) begin
                bad++;
                $display("FAIL b2b_timing: cycle=%0d done=%b busy=%b required %b %b",
                         c1, done, busy, (c1 % 8 == 7), (c1 % 8 != 0));
            end
            if (done === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (s !== e) begin
                    bad++;
                    $display("FAIL b2b_result: s=%h required %h", s, e);
                end
                $display("op b2b cycle=%0d s=%h", c1, s);
            end
        end
        start = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_count: pending=%0d required 0", exp_q.size());
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_walk();
        test_hold();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/left_shift_unit.md
LEFT_SHIFT_UNIT -- requirements
Module: left_shift_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, the datapath width in bits.
REQ-002 The block SHALL have parameter SHAMT_W, default 6, the shift-amount width (log2 XLEN).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a shift, sampled only while busy=0.
REQ-006 The block SHALL have port a, input, XLEN bits: operand to shift, captured on the accepting edge.
REQ-007 The block SHALL have port b, input, SHAMT_W bits: shift amount, captured on the accepting edge.
REQ-008 The block SHALL have port word, input, 1 bit: 1 selects SLLW (32-bit shift, result sign-extended); 0 selects SLL; captured on the accepting edge.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in progress or its result is being presented.
REQ-010 The block SHALL have port done, output, 1 bit: single-cycle pulse marking s valid for a new result.
REQ-011 The block SHALL have port s, output, XLEN bits: shift result, held stable from done until the next done or reset.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the edge (E0) SHALL capture a, b and word, clear the stage counter, and move to SHIFT.
REQ-014 In SHIFT, edges E1..E6 SHALL each apply stage k = 0..5: work <= work << 2^k if captured b[k]=1, else unchanged; k increments each edge.
REQ-015 In word mode, stage 5 SHALL be a no-op regardless of b[5], and latency SHALL be identical to SLL.
REQ-016 At E6, the FSM SHALL move to DONE and load s with the final value: for SLL, the full XLEN result; for word mode, bits [31:0] of the result sign-extended from bit 31.
REQ-017 done SHALL be 1 only in the cycle following E6, and E7 SHALL return the FSM to IDLE.
REQ-018 Fixed latency: done SHALL be asserted exactly 7 edges after the accepting edge, independent of b and word.
REQ-019 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE; start SHALL be ignored while busy=1, with no queuing.
REQ-020 A start asserted in the cycle in which done=1 SHALL be ignored; back-to-back throughput is one operation per 8 cycles.
REQ-021 Shifts SHALL be logical: vacated LSBs zero-filled and bits shifted past bit XLEN-1 discarded.
REQ-022 b=0 SHALL return a unchanged for SLL and sext(a[31:0]) for word mode.
REQ-023 Changes on a, b or word after the accepting edge SHALL NOT affect the operation in flight.

Reset
REQ-024 When reset=1 at an edge, the block SHALL enter IDLE with busy=0, done=0, s=0, stage counter=0, and work register=0.
REQ-025 Reset SHALL take priority over start and SHALL abort any in-flight operation with no done pulse.
REQ-026 The first start SHALL be accepted on the first edge with reset=0.

Structure
REQ-027 Package shifter_pkg SHALL hold XLEN, SHAMT_W, the FSM state enum, and a shift-operation type (SLL/SLLW), for reuse by right_shifter-related blocks.
REQ-028 The single per-cycle stage SHALL be a combinational sub-module left_shift_stage (inputs: value, stage index, enable bit, word flag; output: shifted value), instantiated once.
REQ-029 The block SHALL contain no multi-stage combinational barrel shifter; only one stage SHALL be evaluated per cycle.

Verification
REQ-030 Bench SHALL cover: a=1, b=63, word=0 -> done 7 edges after start, s=0x8000000000000000.
REQ-031 Bench SHALL cover: a=0x00000000_40000001, b=1, word=1 -> s=0xFFFFFFFF_80000002.
REQ-032 Bench SHALL cover: a=0xFFFFFFFF_FFFFFFFF, b=32, word=1 (b[5] ignored) -> s=0xFFFFFFFF_FFFFFFFF; same with word=0 -> s=0xFFFFFFFF_00000000.
REQ-033 Bench SHALL cover: loop i=0..63, a={63'b0,1'b1}, word=0 -> s=1<<i for every i; error count reported and must be 0.
REQ-034 Bench SHALL cover: reset asserted at E3 of an operation -> busy=0, done never pulses, s=0; next start completes normally.
REQ-035 Bench SHALL cover: start held high continuously -> exactly one done per 8 cycles, and start during busy/done cycles is ignored.
